// File: rtl/eth_pkg.sv
// eth_pkg: ICMP type constants, header field offsets, write FSM states and the
// one's-complement checksum fold shared by the echo path.
package eth_pkg;
  localparam logic [7:0] ICMP_TYPE_ECHO_REQ = 8'd8;
  localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'd0;
  localparam int ICMP_TYPE_LSB = 24;
  localparam int ICMP_CODE_LSB = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;
  function automatic logic [15:0] csum_fold(input logic [31:0] acc);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    s2 = s1[15:0] + {15'd0, s1[16]};
    return s2;
  endfunction
endpackage

// File: rtl/csum16_acc.sv
// csum16_acc: 32-bit checksum accumulator with load/add; sum is the folded and
// inverted value of the accumulator as it stands after the current cycle.
module csum16_acc
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        add,
  input  logic [31:0] value,
  output logic [31:0] nxt,
  output logic [15:0] sum
);
  logic [31:0] acc;
  always_comb nxt = load ? value : add ? acc + value : acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      sum <= '0;
    end else begin
      acc <= nxt;
      sum <= ~csum_fold(nxt);
    end
endmodule

// File: rtl/icmp_echo_buffer.sv
// icmp_echo_buffer: two-bank ICMP echo request -> echo reply buffer with on-the-fly checksum.
// Define ICMP_RX_CSUM_CHECK_EN to also drop requests whose received checksum fails to verify.
module icmp_echo_buffer
  import eth_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 8,
  parameter logic [7:0] ECHO_TYPE  = ICMP_TYPE_ECHO_REQ
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_sop,
  input  logic                i_eop,
  input  logic [31:0]         i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [31:0]         o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sop,
  output logic                o_eop,
  output logic [DEPTH_LOG2:0] o_len,
  output logic                o_drop
);
  localparam int AW = DEPTH_LOG2 + 1;
  localparam logic [AW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0] mem [2**AW];
  logic [31:0] rdata, halves, unused_nxt;
  logic [1:0] state, state_nxt, full;
  logic wbank, rbank, pend, pend_bank;
  logic [AW-1:0] wptr, waddr, raddr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [AW-1:0] len_q [2];
  logic [15:0] csum_q [2];
  logic [15:0] csum;
  logic accept, hdr_ok, ovf, in_msg, wr_en, acc_add, commit, bad_end, chk_ok;
  logic start_rd, step_rd, done_rd;

  always_comb begin
    accept = i_valid && o_ready;
    hdr_ok = i_data[ICMP_TYPE_LSB +: 8] == ECHO_TYPE;
    ovf = wptr == DEPTH;
    in_msg = i_sop ? hdr_ok : state == ST_RECV && !ovf;
    wr_en = accept && in_msg;
    acc_add = accept && !i_sop && state == ST_RECV && !ovf;
    commit = accept && i_eop && in_msg && chk_ok;
    bad_end = accept && i_eop && !commit && (i_sop || state != ST_IDLE);
    halves = {16'd0, i_data[31:16]} + {16'd0, i_data[15:0]};
    waddr = {wbank, i_sop ? {DEPTH_LOG2{1'b0}} : wptr[DEPTH_LOG2-1:0]};
    state_nxt = !accept ? state
              : i_sop ? (i_eop ? ST_IDLE : hdr_ok ? ST_RECV : ST_SKIP)
              : i_eop ? ST_IDLE
              : state == ST_RECV && ovf ? ST_SKIP : state;
    start_rd = !o_valid && full[rbank];
    step_rd = o_valid && i_ready && !o_eop;
    done_rd = o_valid && i_ready && o_eop;
    raddr = {rbank, start_rd ? {DEPTH_LOG2{1'b0}} : rptr};
    o_ready = !full[wbank];
    o_data = !o_valid ? '0
           : o_sop ? {ICMP_TYPE_ECHO_REPLY, rdata[ICMP_CODE_LSB +: 8], csum_q[rbank]}
           : rdata;
  end

  // The reply checksum starts from the code byte: the reply type is zero.
  csum16_acc u_acc (
    .clk(clk), .rst_n(rst_n), .load(accept && i_sop), .add(acc_add),
    .value(i_sop ? {24'd0, i_data[ICMP_CODE_LSB +: 8]} : halves),
    .nxt(unused_nxt), .sum(csum)
  );

`ifdef ICMP_RX_CSUM_CHECK_EN
  logic [31:0] chk_nxt;
  logic [15:0] unused_chk_sum;
  csum16_acc u_chk (
    .clk(clk), .rst_n(rst_n), .load(accept && i_sop), .add(acc_add),
    .value(halves), .nxt(chk_nxt), .sum(unused_chk_sum)
  );
  assign chk_ok = csum_fold(chk_nxt) == 16'hFFFF;
`else
  assign chk_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= i_data;
    if (start_rd || step_rd) rdata <= mem[raddr];
  end

  // The fold lands one cycle after eop, so the bank checksum is written from pend.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      wptr <= '0;
      wbank <= 1'b0;
      full <= '0;
      pend <= 1'b0;
      pend_bank <= 1'b0;
      len_q <= '{default: '0};
      csum_q <= '{default: '0};
      o_drop <= 1'b0;
    end else begin
      state <= state_nxt;
      o_drop <= (accept && i_sop && state != ST_IDLE) || bad_end;
      if (wr_en) wptr <= i_sop ? AW'(1) : wptr + 1'b1;
      if (commit) begin
        len_q[wbank] <= i_sop ? AW'(1) : wptr + 1'b1;
        wbank <= ~wbank;
      end
      full <= (full & ~(2'(done_rd) << rbank)) | (2'(commit) << wbank);
      pend <= commit;
      pend_bank <= wbank;
      if (pend) csum_q[pend_bank] <= csum;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rbank <= 1'b0;
      rptr <= '0;
      o_valid <= 1'b0;
      o_sop <= 1'b0;
      o_eop <= 1'b0;
      o_len <= '0;
    end else if (start_rd) begin
      rptr <= DEPTH_LOG2'(1);
      o_valid <= 1'b1;
      o_sop <= 1'b1;
      o_eop <= len_q[rbank] == AW'(1);
      o_len <= len_q[rbank];
    end else if (step_rd) begin
      rptr <= rptr + 1'b1;
      o_sop <= 1'b0;
      o_eop <= {1'b0, rptr} == o_len - 1'b1;
    end else if (done_rd) begin
      rbank <= ~rbank;
      o_valid <= 1'b0;
      o_sop <= 1'b0;
      o_eop <= 1'b0;
    end
endmodule

// File: tb/tb_icmp_echo_buffer.sv
// tb_icmp_echo_buffer: scoreboard bench for icmp_echo_buffer built with DEPTH_LOG2=2.
module tb_icmp_echo_buffer;
  localparam int D = 2;
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [D:0]  len;
  } beat_t;

  logic clk = 0, rst_n = 0, i_sop = 0, i_eop = 0, i_valid = 0, i_ready = 1;
  logic [31:0] i_data = '0;
  logic o_ready, o_valid, o_sop, o_eop, o_drop;
  logic [31:0] o_data;
  logic [D:0] o_len;
  beat_t exp_q[$];
  beat_t mon_e;
  int total = 0, bad = 0, drops = 0;

  always #5 clk = ~clk;

  icmp_echo_buffer #(.DEPTH_LOG2(D), .ECHO_TYPE(8'd8)) dut (
    .clk(clk), .rst_n(rst_n), .i_sop(i_sop), .i_eop(i_eop), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_sop(o_sop), .o_eop(o_eop), .o_len(o_len), .o_drop(o_drop)
  );

  always @(negedge clk) begin
    if (o_drop) drops++;
    if (rst_n && o_valid && i_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got data=%h sop=%b eop=%b len=%0d, wanted no output", o_data, o_sop, o_eop, o_len);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_data, o_sop, o_eop, o_len} !== mon_e) begin
          bad++;
          $display("FAIL out_beat: got data=%h sop=%b eop=%b len=%0d, wanted data=%h sop=%b eop=%b len=%0d",
                   o_data, o_sop, o_eop, o_len, mon_e.data, mon_e.sop, mon_e.eop, mon_e.len);
        end
      end
    end
  end

  function automatic logic [15:0] ref_csum(input logic [31:0] w[$]);
    logic [31:0] a;
    a = {24'd0, w[0][23:16]};
    for (int i = 1; i < w.size(); i++) a = a + {16'd0, w[i][31:16]} + {16'd0, w[i][15:0]};
    a = {16'd0, a[31:16]} + {16'd0, a[15:0]};
    a = {16'd0, a[31:16]} + {16'd0, a[15:0]};
    return ~a[15:0];
  endfunction

  task automatic expect_beat(input logic [31:0] d, input logic s, input logic e, input logic [D:0] l);
    exp_q.push_back({d, s, e, l});
  endtask

  task automatic expect_msg(input logic [31:0] w[$]);
    for (int i = 0; i < w.size(); i++)
      exp_q.push_back({i == 0 ? {8'h00, w[0][23:16], ref_csum(w)} : w[i], 1'(i == 0), 1'(i == w.size() - 1), 3'(w.size())});
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e);
    int n = 0;
    i_data = d; i_sop = s; i_eop = e; i_valid = 1;
    while (!o_ready && n < 200) begin @(negedge clk); n++; end
    total++;
    if (!o_ready) begin bad++; $display("FAIL send_timeout: o_ready=%b after %0d cycles, wanted 1", o_ready, n); end
    @(negedge clk);
    i_valid = 0; i_sop = 0; i_eop = 0;
  endtask

  task automatic send_msg(input logic [31:0] w[$]);
    for (int i = 0; i < w.size(); i++) send(w[i], 1'(i == 0), 1'(i == w.size() - 1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain_timeout: %0d beats pending, wanted 0", exp_q.size()); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({o_ready, o_valid, o_sop, o_eop, o_drop, o_data, o_len} !== {5'b10000, 32'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b sop=%b eop=%b drop=%b data=%h len=%0d, wanted 1 0 0 0 0 0 0",
               o_ready, o_valid, o_sop, o_eop, o_drop, o_data, o_len);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    expect_beat(32'h0000FFFC, 1, 0, 3'd2);
    expect_beat(32'h00010002, 0, 1, 3'd2);
    send(32'h0800ABCD, 1, 0);
    send(32'h00010002, 0, 1);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_n1: o_valid=%b, wanted 0", o_valid); end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_data !== 32'h0000FFFC || o_len !== 3'd2) begin
      bad++;
      $display("FAIL basic_n2: vld=%b data=%h len=%0d, wanted 1 0000fffc 2", o_valid, o_data, o_len);
    end
    drain();
  endtask

  task automatic test_carry();
    expect_beat(32'h0000FFFD, 1, 0, 3'd3);
    expect_beat(32'hFFFFFFFF, 0, 0, 3'd3);
    expect_beat(32'h00000002, 0, 1, 3'd3);
    send(32'h08000000, 1, 0);
    send(32'hFFFFFFFF, 0, 0);
    send(32'h00000002, 0, 1);
    drain();
  endtask

  task automatic test_single();
    expect_beat(32'h0005FFFA, 1, 1, 3'd1);
    send(32'h08051234, 1, 1);
    drain();
  endtask

  task automatic test_overflow();
    int d0 = drops;
    send(32'h08000000, 1, 0);
    for (int i = 1; i < 4; i++) send(32'(i), 0, 0);
    send(32'h4, 0, 1);
    total++;
    if (o_drop !== 1'b1) begin bad++; $display("FAIL overflow_drop_pulse: o_drop=%b, wanted 1", o_drop); end
    repeat (4) @(negedge clk);
    total++;
    if (drops != d0 + 1) begin bad++; $display("FAIL overflow_drop_count: drops=%0d, wanted %0d", drops - d0, 1); end
    expect_beat(32'h0000FFF9, 1, 0, 3'd4);
    for (int i = 1; i < 4; i++) expect_beat(32'(i), 0, 1'(i == 3), 3'd4);
    send(32'h08000000, 1, 0);
    for (int i = 1; i < 4; i++) send(32'(i), 0, 1'(i == 3));
    drain();
    expect_beat(32'h00009753, 1, 0, 3'd2);
    expect_beat(32'h12345678, 0, 1, 3'd2);
    send(32'h08000000, 1, 0);
    send(32'h12345678, 0, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[$], b[$], c[$], hdr_a;
    a.push_back({8'h08, 8'($urandom), 16'($urandom)});
    for (int i = 0; i < 2; i++) a.push_back($urandom);
    b.push_back({8'h08, 8'($urandom), 16'($urandom)});
    b.push_back($urandom);
    c.push_back({8'h08, 8'($urandom), 16'($urandom)});
    for (int i = 0; i < 2; i++) c.push_back($urandom);
    hdr_a = {8'h00, a[0][23:16], ref_csum(a)};
    expect_msg(a);
    expect_msg(b);
    expect_msg(c);
    i_ready = 0;
    send_msg(a);
    send_msg(b);
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL pingpong_ready_low: o_ready=%b, wanted 0", o_ready); end
    fork
      send_msg(c);
    join_none
    repeat (4) @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_sop !== 1'b1 || o_data !== hdr_a || o_len !== 3'd3 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_output: vld=%b sop=%b data=%h len=%0d rdy=%b, wanted 1 1 %h 3 0", o_valid, o_sop, o_data, o_len, o_ready, hdr_a);
    end
    i_ready = 1;
    wait fork;
    drain();
  endtask

  task automatic test_abort_type();
    int d0 = drops;
    expect_beat(32'h0003FFF3, 1, 0, 3'd2);
    expect_beat(32'h00040005, 0, 1, 3'd2);
    send(32'h08000000, 1, 0);
    send(32'h11112222, 0, 0);
    send(32'h08030000, 1, 0);
    total++;
    if (o_drop !== 1'b1) begin bad++; $display("FAIL abort_drop: o_drop=%b, wanted 1", o_drop); end
    send(32'h00040005, 0, 1);
    drain();
    send(32'h00000000, 1, 0);
    send(32'h00000001, 0, 1);
    total++;
    if (o_drop !== 1'b1) begin bad++; $display("FAIL type_drop: o_drop=%b, wanted 1", o_drop); end
    repeat (4) @(negedge clk);
    total++;
    if (drops != d0 + 2) begin bad++; $display("FAIL abort_type_count: drops=%0d, wanted 2", drops - d0); end
  endtask

  task automatic test_reset_mid();
    int d0 = drops;
    i_ready = 0;
    send(32'h08000000, 1, 0);
    send(32'h00000001, 0, 1);
    send(32'h08000000, 1, 0);
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1) begin bad++; $display("FAIL reset_mid_pre: o_valid=%b, wanted 1", o_valid); end
    #2 rst_n = 0;
    #1;
    total++;
    if ({o_valid, o_drop, o_ready} !== 3'b001) begin
      bad++;
      $display("FAIL reset_mid_async: vld=%b drop=%b rdy=%b, wanted 0 0 1", o_valid, o_drop, o_ready);
    end
    @(negedge clk);
    rst_n = 1;
    i_ready = 1;
    repeat (5) @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || drops != d0) begin
      bad++;
      $display("FAIL reset_mid_flush: vld=%b drops=%0d, wanted 0 0", o_valid, drops - d0);
    end
    expect_beat(32'h0000FFFF, 1, 1, 3'd1);
    send(32'h08001111, 1, 1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_single();
    test_overflow();
    test_back_to_back();
    test_abort_type();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
